pc_call_stack: RTL
==================

// Module: pc_call_stack
// PURPOSE
//  Parametrised program counter with an integrated return-address stack for subroutine call/return.
//  Supports load, signed relative branch, call, return, stall and default increment.
//  Sits in the fetch stage and drives the instruction-memory address.
//  Control decode supplies one-cycle enable strobes.
// PARAMETERS
//  WIDTH         16  counter and LoadValue width, bits
//  OFFSET_WIDTH  9   signed Offset width, 2's complement
//  DEPTH         8   return-stack entries; power of 2, >= 2
//  RESET_VALUE   0   CounterValue after reset
// PORTS
//  Clock         in   1                      rising-edge clock
//  nReset        in   1                      asynchronous, active-low reset
//  Stall         in   1                      hold all state this cycle
//  LoadEnable    in   1                      absolute jump to LoadValue
//  CallEnable    in   1                      push CounterValue+1, jump to LoadValue
//  ReturnEnable  in   1                      pop stack top into CounterValue
//  OffsetEnable  in   1                      CounterValue += sign-extended Offset
//  ClearErrors   in   1                      clear sticky error flags
//  Offset        in   OFFSET_WIDTH (signed)  relative branch offset
//  LoadValue     in   WIDTH                  jump/call target
//  CounterValue  out  WIDTH                  current PC, registered
//  StackDepth    out  $clog2(DEPTH)+1        valid entries, 0..DEPTH
//  StackEmpty    out  1                      StackDepth==0
//  StackFull     out  1                      StackDepth==DEPTH
//  Overflow      out  1                      sticky: call issued while full
//  Underflow     out  1                      sticky: return issued while empty
// BEHAVIOUR
//  - Reset (nReset low, async): CounterValue=RESET_VALUE, StackDepth=0, Overflow=Underflow=0.
//    Stack RAM contents are not reset and are don't-care. Reset mid-operation discards any in-flight op.
//  - All updates occur on Clock rising edge. Latency is 1 cycle; no combinational path from inputs to outputs.
//  - Priority per cycle: Stall > LoadEnable > CallEnable > ReturnEnable > OffsetEnable > increment.
//    Lower-priority enables asserted in the same cycle are ignored entirely, with no stack side effects.
//  - Stall: PC, stack and flags hold. ClearErrors is still honoured.
//  - Load: PC <= LoadValue.
//  - Offset: PC <= PC + sign_extend(Offset), modulo 2^WIDTH.
//  - Increment: PC <= PC + 1, modulo 2^WIDTH. All-ones wraps to 0 silently.
//  - Call, not full: push (PC+1) mod 2^WIDTH, depth+1, PC <= LoadValue.
//  - Call, full: circular overwrite of the oldest entry, depth stays DEPTH, Overflow <= 1, PC <= LoadValue.
//  - Return, not empty: PC <= top, depth-1.
//  - Return, empty: PC <= PC+1, depth stays 0, Underflow <= 1.
//  - Stack is circular: the write pointer wraps at DEPTH. The top is read combinationally from the pointer, so pop has no extra latency.
//  - Call then immediate Return on the next cycle returns to call-site+1 (no hazard bubble).
//  - ClearErrors clears both flags. If a new error is set in the same cycle, set wins.
//  - StackEmpty and StackFull are decoded from the registered StackDepth.
// STRUCTURE
//  - Package pc_pkg holds:
//    - typedef enum pc_op_t {PC_HOLD, PC_LOAD, PC_CALL, PC_RET, PC_OFFSET, PC_INC}
//    - function pc_prio_decode(), which maps the enables to pc_op_t
//  - Sub-module return_stack (DEPTH, WIDTH) provides the circular LIFO:
//    - inputs: push, pop, din
//    - outputs: top, depth, full, empty
//  - The top level owns the PC register, next-PC mux and sticky flags.
// TESTING
//  1. Reset, then 5 idle cycles -> CounterValue 0,1,2,3,4; StackEmpty=1.
//  2. PC=0x0010, OffsetEnable, Offset=-3 (9'h1FD) -> PC=0x000D.
//     Then Offset=+255 -> PC=0x010C.
//  3. PC=0x0020, CallEnable, LoadValue=0x0400 -> PC=0x0400, depth=1.
//     Two increments, then ReturnEnable -> PC=0x0021, StackEmpty=1.
//  4. Overflow: 9 nested calls with DEPTH=8 -> Overflow=1, depth=8.
//     8 returns yield the last 8 return addresses in LIFO order.
//     A 9th return -> Underflow=1 and PC increments.
//  5. Simultaneous events:
//     - Load+Call in one cycle -> jump only, depth unchanged.
//     - Stall with Call -> PC and depth hold.
//     - ClearErrors while Stall -> flags 0.
//  6. PC=0xFFFF, increment -> 0x0000.
//     Assert nReset low mid-call (async, between edges) -> PC=0 and depth=0 immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// Package: pc_pkg
// Purpose: shared types and the per-cycle operation decode for the fetch-stage
//          program counter with its return-address stack.
// Contents:
//   pc_op_t        - the single operation the PC performs in a given cycle
//   pc_prio_decode - collapses the control-decode enable strobes into one op,
//                    applying the fixed priority
//                    Stall > Load > Call > Return > Offset > increment
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_LOAD   = 3'd1,
        PC_CALL   = 3'd2,
        PC_RET    = 3'd3,
        PC_OFFSET = 3'd4,
        PC_INC    = 3'd5
    } pc_op_t;

    // Exactly one op wins per cycle; lower-priority enables are dropped, so
    // they can never cause a stray push or pop.
    function automatic pc_op_t pc_prio_decode(
        input logic stall,
        input logic load_en,
        input logic call_en,
        input logic ret_en,
        input logic offset_en
    );
        pc_op_t op;
        if (stall)          op = PC_HOLD;
        else if (load_en)   op = PC_LOAD;
        else if (call_en)   op = PC_CALL;
        else if (ret_en)    op = PC_RET;
        else if (offset_en) op = PC_OFFSET;
        else                op = PC_INC;
        return op;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Module: return_stack
// Purpose: circular LIFO of return addresses. A push when full overwrites the
//          oldest entry (the write pointer already points at it) and keeps the
//          depth at DEPTH. The top entry is read combinationally from the
//          pointer so a pop completes in the same cycle it is requested.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointer and depth only)
//   push, pop   - one-cycle strobes; caller never asserts both, and never pops
//                 when empty
//   din         - address to push
//   top         - most recently pushed valid entry
//   depth       - number of valid entries, 0..DEPTH
//   full, empty - decoded from the registered depth
module return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]    depth_q, depth_d;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;
    assign top   = mem_q[wr_ptr_q - PW'(1)];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        depth_d  = depth_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            depth_d  = full ? depth_q : depth_q + DW'(1);
        end else if (pop && !empty) begin
            wr_ptr_d = wr_ptr_q - PW'(1);
            depth_d  = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            depth_q  <= depth_d;
        end
    end

    // Storage is intentionally not reset; depth alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pc_call_stack.sv
// Module: pc_call_stack
// Purpose: fetch-stage program counter with load, signed relative branch,
//          call/return through an integrated return-address stack, stall and
//          default increment. All outputs are registered or decoded from
//          registers; there is no combinational input-to-output path.
// Ports:
//   Clock, nReset  - rising-edge clock, asynchronous active-low reset
//   Stall          - hold PC, stack and flags (ClearErrors still honoured)
//   LoadEnable     - PC <= LoadValue
//   CallEnable     - push PC+1, PC <= LoadValue
//   ReturnEnable   - PC <= stack top and pop
//   OffsetEnable   - PC <= PC + sign-extended Offset
//   ClearErrors    - clear the sticky Overflow/Underflow flags
//   Offset         - signed relative branch offset
//   LoadValue      - jump/call target
//   CounterValue   - current PC
//   StackDepth     - valid stack entries
//   StackEmpty/Full- decoded from StackDepth
//   Overflow       - sticky: call while full
//   Underflow      - sticky: return while empty
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               OFFSET_WIDTH = 9,
    parameter int               DEPTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                           Clock,
    input  logic                           nReset,
    input  logic                           Stall,
    input  logic                           LoadEnable,
    input  logic                           CallEnable,
    input  logic                           ReturnEnable,
    input  logic                           OffsetEnable,
    input  logic                           ClearErrors,
    input  logic signed [OFFSET_WIDTH-1:0] Offset,
    input  logic [WIDTH-1:0]               LoadValue,
    output logic [WIDTH-1:0]               CounterValue,
    output logic [$clog2(DEPTH):0]         StackDepth,
    output logic                           StackEmpty,
    output logic                           StackFull,
    output logic                           Overflow,
    output logic                           Underflow
);

    localparam int EXT = WIDTH - OFFSET_WIDTH;

    pc_op_t           op;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] offset_ext;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_set, unf_set;
    logic             stk_push, stk_pop;
    logic [WIDTH-1:0] stk_top;
    logic             stk_full, stk_empty;

    assign op         = pc_prio_decode(Stall, LoadEnable, CallEnable,
                                       ReturnEnable, OffsetEnable);
    assign pc_inc     = pc_q + WIDTH'(1);
    assign offset_ext = {{EXT{Offset[OFFSET_WIDTH-1]}}, Offset};

    always_comb begin
        pc_d     = pc_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        case (op)
            PC_HOLD:   pc_d = pc_q;
            PC_LOAD:   pc_d = LoadValue;
            PC_CALL: begin
                pc_d     = LoadValue;
                stk_push = 1'b1;
                ovf_set  = stk_full;
            end
            PC_RET: begin
                // An empty-stack return behaves like a plain increment.
                if (stk_empty) begin
                    pc_d    = pc_inc;
                    unf_set = 1'b1;
                end else begin
                    pc_d    = stk_top;
                    stk_pop = 1'b1;
                end
            end
            PC_OFFSET: pc_d = pc_q + offset_ext;
            default:   pc_d = pc_inc;
        endcase
    end

    // A new error in the same cycle as ClearErrors wins.
    assign ovf_d = (ovf_q & ~ClearErrors) | ovf_set;
    assign unf_d = (unf_q & ~ClearErrors) | unf_set;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc_q  <= RESET_VALUE;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    return_stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_return_stack (
        .clk   (Clock),
        .rst_n (nReset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .top   (stk_top),
        .depth (StackDepth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign CounterValue = pc_q;
    assign StackEmpty   = stk_empty;
    assign StackFull    = stk_full;
    assign Overflow     = ovf_q;
    assign Underflow    = unf_q;

endmodule
